// File: rtl/spi_codeload_master.sv
// -----------------------------------------------------------------------------
// spi_codeload_master
//
// Boot-time SPI master. It sends one READ (0x03) command with a 24-bit flash
// address, then streams WORDS little-endian 32-bit words from the flash into
// the instruction memory write port. The SPI bus runs in mode 0 (sck idles
// low, miso is sampled on the rising edge, mosi changes on the falling edge).
//
// Ports
//   clk          in   1       system clock
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       one-cycle pulse; accepted only in IDLE or DONE
//   ss           out  1       flash chip select, active low
//   sck          out  1       SPI clock, idles low
//   mosi         out  1       command bits to the flash, MSB first
//   miso         in   1       data bits from the flash, MSB first per byte
//   mem_we       out  1       one-cycle imem write strobe
//   mem_addr     out  ADDR_W  word address of the write (held until next write)
//   mem_wdata    out  32      write data (held until next write)
//   busy         out  1       high from start accept until DONE is entered
//   done         out  1       sticky completion flag, cleared by the next start
//   dbg_state_o  out  3       current FSM state, for observation only
//
// Handshake: start is a fire-and-forget request, taken on any clk edge where
// the FSM sits in IDLE or DONE; there is no ready. mem_we is a write-only
// strobe with no back-pressure: the memory must accept every pulse.
// -----------------------------------------------------------------------------
module spi_codeload_master #(
    parameter int          CLK_DIV    = 2,
    parameter int          WORDS      = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [23:0] FLASH_BASE = 24'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              ss,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [2:0]        dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_DATA   = 3'd2,
        S_FINISH = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    localparam int          DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    // One extra bit so the word counter can hold WORDS itself (load finished).
    localparam int          WC_W     = ADDR_W + 1;
    localparam logic [31:0] CMD_WORD = {8'h03, FLASH_BASE};

    state_t            state_q;
    logic [DIV_W-1:0]  div_q;
    logic              sck_q;
    logic              ss_q;
    logic              mosi_q;
    logic [30:0]       sh_q;       // command bits still to be sent after mosi_q
    logic [30:0]       rx_q;       // bits of the current word received so far
    logic [4:0]        bit_q;      // cmd: falling edges seen; data: rising edges in word
    logic [WC_W-1:0]   word_q;     // index of the word being received
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              busy_q;
    logic              done_q;

    logic              tick;
    logic [31:0]       rx_next;
    logic [31:0]       rx_swapped;

    // Half-period of sck elapses on this clk edge.
    assign tick       = (div_q == DIV_W'(CLK_DIV - 1));
    assign rx_next    = {rx_q, miso};
    // Bytes arrive MSB first, so the first byte lands in [31:24] of the shift
    // register; the word is little-endian, so swap bytes on the way out.
    assign rx_swapped = {rx_next[7:0], rx_next[15:8], rx_next[23:16], rx_next[31:24]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            sck_q   <= 1'b0;
            ss_q    <= 1'b1;
            mosi_q  <= 1'b0;
            sh_q    <= '0;
            rx_q    <= '0;
            bit_q   <= '0;
            word_q  <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_q <= S_CMD;
                        ss_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        sh_q    <= CMD_WORD[30:0];
                        mosi_q  <= CMD_WORD[31];
                        word_q  <= '0;
                        bit_q   <= '0;
                        div_q   <= '0;
                        sck_q   <= 1'b0;
                    end
                end

                S_CMD: begin
                    if (tick) begin
                        div_q <= '0;
                        sck_q <= ~sck_q;
                        if (sck_q) begin
                            // Falling edge: present the next command bit.
                            if (bit_q == 5'd31) begin
                                state_q <= S_DATA;
                                mosi_q  <= 1'b0;
                                bit_q   <= '0;
                            end else begin
                                mosi_q <= sh_q[30];
                                sh_q   <= {sh_q[29:0], 1'b0};
                                bit_q  <= bit_q + 5'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                S_DATA: begin
                    if (tick) begin
                        div_q <= '0;
                        if (sck_q) begin
                            // Falling edge. Once every word has been written,
                            // this edge closes the bus instead of continuing.
                            sck_q <= 1'b0;
                            if (word_q == WC_W'(WORDS)) begin
                                state_q <= S_FINISH;
                            end
                        end else begin
                            // Rising edge: sample miso.
                            sck_q <= 1'b1;
                            rx_q  <= rx_next[30:0];
                            if (bit_q == 5'd31) begin
                                we_q    <= 1'b1;
                                addr_q  <= word_q[ADDR_W-1:0];
                                wdata_q <= rx_swapped;
                                word_q  <= word_q + WC_W'(1);
                                bit_q   <= '0;
                            end else begin
                                bit_q <= bit_q + 5'd1;
                            end
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                S_FINISH: begin
                    // sck is already low; keep ss low for one more half period,
                    // raise it, then report completion on the following cycle.
                    if (ss_q) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (tick) begin
                        ss_q  <= 1'b1;
                        div_q <= '0;
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign ss          = ss_q;
    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule
